// File: rtl/ps_lane_scheduler.sv
// rtl/ps_lane_scheduler.sv - slot sequencer feeding the 2-bit serializer: comma training, then round-robin byte lane
// One 9-bit {valid, byte} word per slot; all state moves only at slot boundaries.
module ps_lane_scheduler #(
  parameter int         SLOT_CYCLES  = 4,
  parameter int         TRAIN_COMMAS = 4,
  parameter logic [7:0] COMMA        = 8'hBC,
  parameter logic [7:0] IDLE_CHAR    = 8'h7C
) (
  input  logic       clk16f,
  input  logic       reset,
  input  logic       enable,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [8:0] paralelo,
  output logic       load,
  output logic [1:0] grant,
  output logic [1:0] state,
  output logic       active
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int TW = (TRAIN_COMMAS > 1) ? $clog2(TRAIN_COMMAS + 1) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_COMMAS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_TRAIN  = 2'b01,
    S_ACTIVE = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   slot_cnt;
  logic            boundary;
  logic [TW-1:0]   train_cnt;
  logic [TW-1:0]   train_d;
  logic            last_grant;   // 0 = req0 owned the last granted slot, 1 = req1
  logic            last_d;
  logic [8:0]      word_d;
  logic [1:0]      grant_d;
  logic            pick0;
  logic            pick1;

  assign boundary = (slot_cnt == SLOT_LAST) && !reset;

  // On a tie the requester that did not own the last granted slot wins.
  always_comb begin
    pick0 = req0_valid && (!req1_valid || last_grant);
    pick1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_comb begin
    state_d = state_q;
    train_d = train_cnt;
    last_d  = last_grant;
    word_d  = {1'b0, IDLE_CHAR};
    grant_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_TRAIN;
          train_d = '0;
        end
      end
      S_TRAIN: begin
        word_d  = {1'b1, COMMA};
        train_d = train_cnt + TW'(1);
        if (!enable) begin
          state_d = S_IDLE;
          train_d = '0;
        end else if (train_cnt == TRAIN_LAST) begin
          state_d = S_ACTIVE;
          train_d = '0;
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (pick0) begin
          word_d  = {1'b1, req0_data};
          grant_d = 2'b01;
          last_d  = 1'b0;
        end else if (pick1) begin
          word_d  = {1'b1, req1_data};
          grant_d = 2'b10;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A ready is only offered on the edge that actually latches the byte.
  assign req0_ready = boundary && (state_q == S_ACTIVE) && enable && pick0;
  assign req1_ready = boundary && (state_q == S_ACTIVE) && enable && pick1;

  always_ff @(posedge clk16f) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (boundary) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk16f) begin
    if (reset) begin
      slot_cnt   <= '0;
      paralelo   <= 9'h000;
      load       <= 1'b0;
      grant      <= 2'b00;
      train_cnt  <= '0;
      last_grant <= 1'b1;
    end else begin
      load     <= boundary;
      slot_cnt <= boundary ? '0 : slot_cnt + CW'(1);
      if (boundary) begin
        paralelo   <= word_d;
        grant      <= grant_d;
        train_cnt  <= train_d;
        last_grant <= last_d;
      end
    end
  end

  assign state  = state_q;
  assign active = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_ps_lane_scheduler.sv
// tb/tb_ps_lane_scheduler.sv - self-checking bench for ps_lane_scheduler
// Slot-level vector table, hand-written reset sequence and randomized traffic against a slot model.
module tb_ps_lane_scheduler;

  localparam int SLOT_CYCLES = 4;
  localparam int TRAIN_COMMAS = 4;

  logic       clk16f = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic [8:0] paralelo;
  logic       load;
  logic [1:0] grant;
  logic [1:0] state;
  logic       active;

  always #5 clk16f = ~clk16f;

  ps_lane_scheduler dut (
    .clk16f     (clk16f),
    .reset      (reset),
    .enable     (enable),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .paralelo   (paralelo),
    .load       (load),
    .grant      (grant),
    .state      (state),
    .active     (active)
  );

  int checks = 0;
  int errors = 0;

  // Slot model: mode 0 idle, 1 training, 2 active; owner index of last grant.
  int         m_cyc = 0;
  int         m_mode = 0;
  int         m_commas = 0;
  int         m_last = 1;
  logic [8:0] m_par = 9'h000;
  logic [1:0] m_grant = 2'b00;
  logic       m_load = 1'b0;
  logic       seen_r0;
  logic       seen_r1;

  typedef struct {
    logic       en;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [8:0] word;
    logic [1:0] gnt;
    logic [1:0] st;
    logic       r0;
    logic       r1;
  } slot_vec_t;

  slot_vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic slot_vec_t mk(input logic en, input logic v0, input logic [7:0] d0,
                                   input logic v1, input logic [7:0] d1, input logic [8:0] word,
                                   input logic [1:0] gnt, input logic [1:0] st,
                                   input logic r0, input logic r1);
    slot_vec_t v;
    v.en = en; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.word = word; v.gnt = gnt; v.st = st; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  // One clock: drive at negedge, check readys, advance model, check registered outputs after posedge.
  task automatic step(input logic r, input logic en, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    int   owner;
    logic bd;
    logic e0;
    logic e1;
    @(negedge clk16f);
    reset = r; enable = en;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    #1;
    bd = !r && (m_cyc == SLOT_CYCLES - 1);
    owner = -1;
    if (v0 && v1) owner = (m_last == 1) ? 0 : 1;
    else if (v0) owner = 0;
    else if (v1) owner = 1;
    e0 = bd && (m_mode == 2) && en && (owner == 0);
    e1 = bd && (m_mode == 2) && en && (owner == 1);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    seen_r0 = req0_ready;
    seen_r1 = req1_ready;

    if (r) begin
      m_cyc = 0; m_mode = 0; m_commas = 0; m_last = 1;
      m_par = 9'h000; m_grant = 2'b00; m_load = 1'b0;
    end else begin
      m_load = bd;
      m_cyc = (m_cyc + 1) % SLOT_CYCLES;
      if (bd) begin
        m_par = 9'h07C;
        m_grant = 2'b00;
        if (m_mode == 0) begin
          if (en) begin m_mode = 1; m_commas = 0; end
        end else if (m_mode == 1) begin
          m_par = 9'h1BC;
          m_commas++;
          if (!en) begin m_mode = 0; m_commas = 0; end
          else if (m_commas == TRAIN_COMMAS) m_mode = 2;
        end else begin
          if (!en) m_mode = 0;
          else if (owner >= 0) begin
            m_par = {1'b1, (owner == 0) ? d0 : d1};
            m_grant = (owner == 0) ? 2'b01 : 2'b10;
            m_last = owner;
          end
        end
      end
    end

    @(posedge clk16f);
    #1;
    check("paralelo", 32'(paralelo), 32'(m_par));
    check("grant", 32'(grant), 32'(m_grant));
    check("state", 32'(state), 32'(m_mode));
    check("active", 32'(active), 32'(m_mode == 2));
    check("load", 32'(load), 32'(m_load));
  endtask

  task automatic run_slot(input slot_vec_t v, input int idx);
    for (int i = 0; i < SLOT_CYCLES; i++) begin
      step(1'b0, v.en, v.v0, v.d0, v.v1, v.d1);
      if (i == SLOT_CYCLES - 1) begin
        check($sformatf("vec%0d_r0", idx), 32'(seen_r0), 32'(v.r0));
        check($sformatf("vec%0d_r1", idx), 32'(seen_r1), 32'(v.r1));
      end
    end
    check($sformatf("vec%0d_word", idx), 32'(paralelo), 32'(v.word));
    check($sformatf("vec%0d_grant", idx), 32'(grant), 32'(v.gnt));
    check($sformatf("vec%0d_state", idx), 32'(state), 32'(v.st));
    check($sformatf("vec%0d_active", idx), 32'(active), 32'(v.st == 2'b10));
    check($sformatf("vec%0d_load", idx), 32'(load), 32'd1);
  endtask

  initial begin
    logic       rv0;
    logic       rv1;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       en_r;
    logic       r;
    int         r1_during_reset;

    // T1 idle, T2 training
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 9'h07C, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h07C, 2'b00, 2'b01, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h1BC, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h1BC, 2'b00, 2'b10, 0, 0));
    // T4 alternation, req0 first after training
    tbl.push_back(mk(1, 1, 8'h11, 1, 8'h22, 9'h111, 2'b01, 2'b10, 1, 0));
    tbl.push_back(mk(1, 1, 8'h11, 1, 8'h22, 9'h122, 2'b10, 2'b10, 0, 1));
    tbl.push_back(mk(1, 1, 8'h11, 1, 8'h22, 9'h111, 2'b01, 2'b10, 1, 0));
    tbl.push_back(mk(1, 1, 8'h11, 1, 8'h22, 9'h122, 2'b10, 2'b10, 0, 1));
    // T3 single requester
    tbl.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 9'h1A5, 2'b01, 2'b10, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h5A, 9'h15A, 2'b10, 2'b10, 0, 1));
    // T5 empty slot, disable, re-enable needs training
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h07C, 2'b00, 2'b10, 0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 8'h00, 9'h07C, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h07C, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 8'h44, 1, 8'h55, 9'h1BC, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h1BC, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h1BC, 2'b00, 2'b01, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 9'h1BC, 2'b00, 2'b10, 0, 0));

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    check("reset_paralelo", 32'(paralelo), 32'h000);
    check("reset_state", 32'(state), 32'd0);
    for (int i = 0; i < tbl.size(); i++) run_slot(tbl[i], i);

    // T6: reset mid-slot while req1 waits; no ready may escape
    r1_during_reset = 0;
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99);
    if (seen_r1) r1_during_reset++;
    check("t6_paralelo", 32'(paralelo), 32'h000);
    check("t6_state", 32'(state), 32'd0);
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_load", 32'(load), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99);
    if (seen_r1) r1_during_reset++;
    check("t6_no_ready", 32'(r1_during_reset), 32'd0);
    for (int i = 0; i < SLOT_CYCLES; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h99);
    check("t6_idle_after_reset", 32'(paralelo), 32'h07C);

    // Randomized traffic with occasional enable toggles and resets
    rv0 = 1'b0; rv1 = 1'b1; rd0 = 8'h00; rd1 = 8'h99; en_r = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) en_r = !en_r;
      step(r, en_r, rv0, rd0, rv1, rd1);
      if (rv0 && seen_r0) begin
        rv0 = ($urandom_range(0, 3) != 0); rd0 = 8'($urandom);
      end else if (rv0 && $urandom_range(0, 31) == 0) begin
        rv0 = 1'b0;
      end else if (!rv0 && $urandom_range(0, 1) == 1) begin
        rv0 = 1'b1; rd0 = 8'($urandom);
      end
      if (rv1 && seen_r1) begin
        rv1 = ($urandom_range(0, 3) != 0); rd1 = 8'($urandom);
      end else if (rv1 && $urandom_range(0, 31) == 0) begin
        rv1 = 1'b0;
      end else if (!rv1 && $urandom_range(0, 1) == 1) begin
        rv1 = 1'b1; rd1 = 8'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
